// File: rtl/pc_gen_pkg.sv
// Shared types and constants for the PC generator: FSM state encoding and
// the instruction alignments the generator supports.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } pc_state_e;

  localparam int IALIGN_16 = 2;
  localparam int IALIGN_32 = 4;

endpackage

// File: rtl/pc_redirect_sel.sv
// Combinational next-PC selection: fixed-priority redirect choice plus the
// alignment check on whichever redirect target wins.
module pc_redirect_sel
  import pc_gen_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int IALIGN = IALIGN_32
) (
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] pc_plus_i,
  input  logic            accept_i,
  input  logic            trap_only_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic [XLEN-1:0] next_pc_o,
  output logic            redirect_o,
  output logic            misalign_o
);

  localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(IALIGN - 1);

  logic [XLEN-1:0] target;

  // Only the highest-priority active source is examined, so a misaligned
  // lower-priority target never masks an aligned higher-priority one.
  always_comb begin
    target     = pc_i;
    redirect_o = 1'b0;
    if (trap_i) begin
      target     = trap_vector_i;
      redirect_o = 1'b1;
    end else if (!trap_only_i && mret_i) begin
      target     = epc_i;
      redirect_o = 1'b1;
    end else if (!trap_only_i && br_taken_i) begin
      target     = br_target_i;
      redirect_o = 1'b1;
    end
  end

  assign misalign_o = redirect_o && ((target & ALIGN_MASK) != '0);

  always_comb begin
    next_pc_o = pc_i;
    if (redirect_o) begin
      if (!misalign_o) next_pc_o = target;
    end else if (accept_i && !trap_only_i) begin
      next_pc_o = pc_plus_i;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator: BOOT/RUN/HALT sequencing, the PC register and the
// registered misalignment pulse.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              IALIGN       = IALIGN_32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  input  logic            trap_i,
  input  logic [XLEN-1:0] trap_vector_i,
  input  logic            mret_i,
  input  logic [XLEN-1:0] epc_i,
  input  logic            halt_i,
  input  logic            fetch_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic            pc_valid_o,
  output logic [XLEN-1:0] pc_plus_o,
  output logic            misalign_o,
  output logic [1:0]      state_o
);

  pc_state_e       state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            misalign_q, misalign_d;

  logic            active;
  logic            accept;
  logic [XLEN-1:0] sel_pc;
  logic            sel_redirect;
  logic            sel_misalign;

  assign active     = (state_q == RUN) || (state_q == HALT);
  assign pc_valid_o = (state_q == RUN);
  assign accept     = pc_valid_o && fetch_ready_i && !stall_i;
  assign pc_plus_o  = pc_q + XLEN'(IALIGN);

  // A pending halt suppresses everything except a trap, just as HALT does.
  pc_redirect_sel #(
    .XLEN   (XLEN),
    .IALIGN (IALIGN)
  ) u_sel (
    .pc_i          (pc_q),
    .pc_plus_i     (pc_plus_o),
    .accept_i      (accept),
    .trap_only_i   ((state_q == HALT) || halt_i),
    .trap_i        (trap_i),
    .trap_vector_i (trap_vector_i),
    .mret_i        (mret_i),
    .epc_i         (epc_i),
    .br_taken_i    (br_taken_i),
    .br_target_i   (br_target_i),
    .next_pc_o     (sel_pc),
    .redirect_o    (sel_redirect),
    .misalign_o    (sel_misalign)
  );

  always_comb begin
    state_d    = state_q;
    pc_d       = active ? sel_pc : pc_q;
    misalign_d = active && sel_misalign;
    case (state_q)
      BOOT: state_d = RUN;
      RUN:  if (halt_i && !trap_i) state_d = HALT;
      HALT: if (sel_redirect && !sel_misalign) state_d = RUN;
      default: begin
        state_d    = RUN;
        pc_d       = pc_q;
        misalign_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BOOT;
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

  assign pc_o       = pc_q;
  assign misalign_o = misalign_q;
  assign state_o    = state_q;

endmodule
